// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter and the write-pointer logic.
package fifo_wr_arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after rr_ptr.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        cand;

  // Rotate so that rr_ptr lands on bit 0, then take the lowest set bit.
  always_comb begin
    rot  = NUM_REQ'({req, req} >> rr_ptr);
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any && rot[i]) begin
        any  = 1'b1;
        cand = 32'(rr_ptr) + i;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end
        idx = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO RAM write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned IDW = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ),
  localparam int unsigned CW  = (clog2(BURST_LEN + 1) < 1) ? 1 : clog2(BURST_LEN + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy,
  output logic [IDW-1:0]                owner_id
);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           owner_req;
  logic           accept;
  logic [IDW-1:0] owner_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  // Owner's request level and the rotation successor of the owner.
  always_comb begin
    owner_req = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        owner_req = req[i];
      end
    end
    owner_next = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + IDW'(1);
    accept     = (state_q == ARB_BURST) && owner_req && !wfull;
  end

  // State, owner, rotation pointer and burst counter registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: select in IDLE, count accepts and release in BURST.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (!owner_req) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = owner_next;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST_LEN - 1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = owner_next;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: one-hot accept strobe and the owner's data slice.
  always_comb begin
    gnt   = '0;
    wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDW'(i)) begin
        gnt[i] = accept;
        wdata  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    wen      = |gnt;
    busy     = (state_q == ARB_BURST);
    owner_id = owner_q;
  end

endmodule
